// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced 3-to-8 decoder.
package decoder_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned DATA_W = 8;

    // Decoder phase: waiting for a word, driving the one-hot line, or resting in the gap.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } dec_state_t;

    // Word arriving from the encoder side.
    typedef struct packed {
        logic              idle;
        logic [CODE_W-1:0] code;
    } dec_word_t;

    // One-hot line selected by a binary code.
    function automatic logic [DATA_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
        return DATA_W'(1) << code;
    endfunction

endpackage

// File: rtl/dec_hold_cnt.sv
// Loadable down-counter shared by the DRIVE and GAP phases; saturates at zero.
module dec_hold_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load has priority over decrement; never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder3x8_seq.sv
// Sequenced 3-to-8 decoder: accepts {idle, code} words over valid/ready, drives
// the one-hot line for HOLD_CYCLES, then an all-zero gap of GAP_CYCLES.
// Optional feature macro: DECODE_OVERRUN_EN (sticky dropped-word flag).
import decoder_pkg::*;

module decoder3x8_seq #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic              in_idle,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    input  logic              clr_ovr,
    output logic              overrun
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0)  ? CNT_W'(GAP_CYCLES - 1)  : '0;
    localparam logic             HAS_GAP   = (GAP_CYCLES > 0);

    dec_state_t        state_q;
    dec_state_t        state_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic              busy_q;
    logic              busy_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;

    dec_word_t         in_word;
    logic              accept;

    assign in_word  = '{idle: in_idle, code: in_code};
    assign in_ready = (state_q == IDLE) && en;
    assign accept   = in_valid && in_ready;

    dec_hold_cnt #(
        .CNT_W(CNT_W)
    ) u_hold_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state and output decode; en low aborts to IDLE from any phase.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        if (!en) begin
            state_d      = IDLE;
            data_d       = '0;
            out_valid_d  = 1'b0;
            busy_d       = 1'b0;
            cnt_load     = 1'b1;
            cnt_load_val = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Idle-flagged words are consumed without driving anything.
                    if (accept && !in_word.idle) begin
                        data_d       = decode_onehot(in_word.code);
                        out_valid_d  = 1'b1;
                        busy_d       = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_LOAD;
                        state_d      = DRIVE;
                    end
                end
                DRIVE: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
                        data_d      = '0;
                        out_valid_d = 1'b0;
                        if (HAS_GAP) begin
                            cnt_load     = 1'b1;
                            cnt_load_val = GAP_LOAD;
                            state_d      = GAP;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    data_d      = '0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

`ifdef DECODE_OVERRUN_EN
    logic overrun_q;
    logic overrun_d;

    // Sticky dropped-word flag; a new drop on the clearing edge wins.
    always_comb begin
        overrun_d = overrun_q;
        if (en && in_valid && !in_ready) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    // Overrun register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_clr_ovr;

    assign unused_clr_ovr = clr_ovr;
    assign overrun        = 1'b0;
`endif

    // The output lines must never carry more than one asserted bit.
    a_data_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(data_out));

endmodule

// File: tb/tb_decoder3x8_seq.sv
// Randomized self-checking bench for decoder3x8_seq against a cycle-timeline model.
module tb_decoder3x8_seq;

    localparam int unsigned H = 4;
    localparam int unsigned G = 1;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic       in_idle;
    logic [2:0] in_code;
    logic       in_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       busy;
    logic       clr_ovr;
    logic       overrun;

    int n_tests;
    int n_fail;

    // Model: k = cycles elapsed since the accepting edge (0 = idle).
    int         k;
    logic [2:0] code_m;
    logic       ovr_m;

    decoder3x8_seq #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_idle   (in_idle),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .clr_ovr   (clr_ovr),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_data();
        logic [7:0] one;
        one = 8'd1;
        return (k >= 1 && k <= int'(H)) ? (one << code_m) : 8'h00;
    endfunction

    task automatic check_outputs();
        check_eq("data_out",  32'(data_out),  32'(exp_data()));
        check_eq("out_valid", 32'(out_valid), 32'(k >= 1 && k <= int'(H)));
        check_eq("busy",      32'(busy),      32'(k >= 1));
        check_eq("overrun",   32'(overrun),   32'(ovr_m));
    endtask

    // One clock: drive at negedge, check ready, advance model at posedge, check outputs.
    task automatic cycle(input logic v, input logic idl, input logic [2:0] c,
                         input logic e, input logic clr);
        logic rdy;
        en       = e;
        in_valid = v;
        in_idle  = idl;
        in_code  = c;
        clr_ovr  = clr;
        #1;
        rdy = (k == 0) && e;
        check_eq("in_ready", 32'(in_ready), 32'(rdy));
        @(posedge clk);
        if (!e) begin
            k = 0;
        end else if (rdy && v) begin
            if (!idl) begin
                k      = 1;
                code_m = c;
            end
        end else if (k > 0) begin
            k = (k == int'(H + G)) ? 0 : k + 1;
        end
`ifdef DECODE_OVERRUN_EN
        if (e && v && !rdy) ovr_m = 1'b1;
        else if (clr)       ovr_m = 1'b0;
`endif
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    int hits;
    int accepts;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        k        = 0;
        code_m   = 3'd0;
        ovr_m    = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        in_idle  = 1'b0;
        in_code  = 3'd0;
        clr_ovr  = 1'b0;

        // Reset state.
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset mid-DRIVE.
        cycle(1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        k     = 0;
        ovr_m = 1'b0;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

        // Every code once from IDLE.
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, 1'b0, 3'(c), 1'b1, 1'b0);
            idle_cycles(int'(H + G));
        end

        // Valid held high with code 5: one accept per 1+H+G cycles.
        hits    = 0;
        accepts = 0;
        for (int i = 0; i < 3 * int'(1 + H + G); i++) begin
            if (in_ready && in_valid) accepts++;
            cycle(1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
            if (data_out == 8'h20) hits++;
        end
        check_eq("held_hits", 32'(hits), 32'(3 * H));
        idle_cycles(int'(H + G + 1));

        // Idle-flagged word is consumed without driving.
        cycle(1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

        // en dropped during the second DRIVE cycle, then a fresh accept.
        cycle(1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 3'd7, 1'b1, 1'b0);
        idle_cycles(int'(H + G));

        // Word offered while busy, then a clear pulse.
        cycle(1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        idle_cycles(int'(H + G));
        cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(1'(($urandom % 3) != 0),
                  1'(($urandom % 8) == 0),
                  3'($urandom % 8),
                  1'(($urandom % 16) != 0),
                  1'(($urandom % 8) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
